// File: rtl/mphase_pkg.sv
// mphase_pkg: shared types and constants for the multi-phase gate driver.
// Build macro MPH_LOWSIDE_INV_EN selects an active-low low-side drive.
package mphase_pkg;

  localparam int NPH_DEF  = 3;
  localparam int DTW_DEF  = 8;
  localparam int DEAD_MIN = 1;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_HI,
    ST_LO,
    ST_DEAD
  } leg_st_t;

`ifdef MPH_LOWSIDE_INV_EN
  localparam logic LS_ON = 1'b0;
`else
  localparam logic LS_ON = 1'b1;
`endif
  localparam logic LS_OFF = ~LS_ON;

endpackage

// File: rtl/mphase_leg.sv
// mphase_leg: one bridge leg - OFF/HI/LO/DEAD FSM, dead counter, gate regs.
// In: clk, rst_n, h_req, l_req, en, stop, dead_cyc. Out: h_gate, l_gate, busy.
module mphase_leg
  import mphase_pkg::*;
#(
  parameter int DTW = DTW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           h_req,
  input  logic           l_req,
  input  logic           en,
  input  logic           stop,
  input  logic [DTW-1:0] dead_cyc,
  output logic           h_gate,
  output logic           l_gate,
  output logic           busy
);

  leg_st_t        st, st_nx, tgt;
  logic [DTW-1:0] cnt, cnt_nx;
  logic [DTW-1:0] dmin, dead_ld;

  assign dmin = DTW'(DEAD_MIN);

  // dead window of max(dead_cyc,1) cycles: counter runs N-1 .. 0
  assign dead_ld = (dead_cyc < dmin) ? dmin - DTW'(1)
                                     : dead_cyc - DTW'(1);

  always_comb begin
    tgt = ST_OFF;
    if (stop || !en || (h_req && l_req))
      tgt = ST_OFF;
    else if (h_req)
      tgt = ST_HI;
    else if (l_req)
      tgt = ST_LO;
  end

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    unique case (st)
      ST_OFF: begin
        if (tgt != ST_OFF)
          st_nx = tgt;
      end
      ST_HI, ST_LO: begin
        if (tgt != st) begin
          st_nx  = ST_DEAD;
          cnt_nx = dead_ld;
        end
      end
      ST_DEAD: begin
        // target is only looked at on expiry, never restarts the count
        if (cnt == '0)
          st_nx = tgt;
        else
          cnt_nx = cnt - DTW'(1);
      end
      default: st_nx = ST_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= ST_OFF;
      cnt <= '0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
    end
  end

  // output stage: reset drops gates at once, no dead completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_gate <= 1'b0;
      l_gate <= LS_OFF;
      busy   <= 1'b0;
    end else begin
      h_gate <= (st == ST_HI);
      l_gate <= (st == ST_LO) ? LS_ON : LS_OFF;
      busy   <= (st == ST_DEAD);
    end
  end

endmodule

// File: rtl/mphase_gatedrv.sv
// mphase_gatedrv: NPH-leg gate driver with dead time and sticky fault flag.
// Ports: clkI,nRstI,hReqI,lReqI,phEnI,forceStopI,deadCycI,faultClrI -> hPo,lNo,faultO,busyO.
// MPH_LOWSIDE_INV_EN makes lNo active-low.
module mphase_gatedrv
  import mphase_pkg::*;
#(
  parameter int NPH = NPH_DEF,
  parameter int DTW = DTW_DEF
) (
  input  logic           clkI,
  input  logic           nRstI,
  input  logic [NPH-1:0] hReqI,
  input  logic [NPH-1:0] lReqI,
  input  logic [NPH-1:0] phEnI,
  input  logic           forceStopI,
  input  logic [DTW-1:0] deadCycI,
  input  logic           faultClrI,
  output logic [NPH-1:0] hPo,
  output logic [NPH-1:0] lNo,
  output logic           faultO,
  output logic [NPH-1:0] busyO
);

  logic [NPH-1:0] s_h, s_l, s_en;
  logic           s_stop, s_clr;
  logic           f_set;

  always_ff @(posedge clkI) begin
    if (!nRstI) begin
      s_h    <= '0;
      s_l    <= '0;
      s_en   <= '0;
      s_stop <= 1'b0;
      s_clr  <= 1'b0;
    end else begin
      s_h    <= hReqI;
      s_l    <= lReqI;
      s_en   <= phEnI;
      s_stop <= forceStopI;
      s_clr  <= faultClrI;
    end
  end

  assign f_set = |(s_en & s_h & s_l);

  // set has priority over a coincident clear
  always_ff @(posedge clkI) begin
    if (!nRstI)
      faultO <= 1'b0;
    else if (f_set)
      faultO <= 1'b1;
    else if (s_clr)
      faultO <= 1'b0;
  end

  for (genvar i = 0; i < NPH; i++) begin : g_leg
    mphase_leg #(.DTW(DTW)) u_leg (
      .clk      (clkI),
      .rst_n    (nRstI),
      .h_req    (s_h[i]),
      .l_req    (s_l[i]),
      .en       (s_en[i]),
      .stop     (s_stop),
      .dead_cyc (deadCycI),
      .h_gate   (hPo[i]),
      .l_gate   (lNo[i]),
      .busy     (busyO[i])
    );
  end

endmodule

// File: tb/tb_mphase_gatedrv.sv
// tb_mphase_gatedrv: directed + random checks of mphase_gatedrv (NPH=3).
// Low-side active level follows MPH_LOWSIDE_INV_EN.
module tb_mphase_gatedrv;

  localparam int N = 3;

`ifdef MPH_LOWSIDE_INV_EN
  localparam logic LON = 1'b0;
`else
  localparam logic LON = 1'b1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] h, l, en;
  logic         stop, clr;
  logic [7:0]   dc;
  logic [N-1:0] hp, ln, busy;
  logic         fault;
  logic [N-1:0] lon_v;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign lon_v = ln ~^ {N{LON}};

  mphase_gatedrv #(.NPH(N), .DTW(8)) dut (
    .clkI       (clk),
    .nRstI      (rst_n),
    .hReqI      (h),
    .lReqI      (l),
    .phEnI      (en),
    .forceStopI (stop),
    .deadCycI   (dc),
    .faultClrI  (clr),
    .hPo        (hp),
    .lNo        (ln),
    .faultO     (fault),
    .busyO      (busy)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    int n, k, need;
    int last [N];
    int run  [N];
    logic [7:0] dcs [3];

    rst_n = 1'b0; h = '0; l = '0; en = '0;
    stop = 1'b0; clr = 1'b0; dc = 8'd4;
    step(3);
    chk("rst_hpo",   hp,    3'b000);
    chk("rst_lno",   ln,    {N{~LON}});
    chk("rst_fault", fault, 0);
    chk("rst_busy",  busy,  3'b000);
    rst_n = 1'b1;
    en = '1;
    step(2);

    // HI then LO with dead=4
    h = 3'b001;
    step(2);
    chk("a_lat2", hp[0], 0);
    step(1);
    chk("a_lat3", hp[0], 1);
    step(3);
    h = 3'b000; l = 3'b001;
    step(2);
    chk("a_hold", hp[0], 1);
    step(1);
    chk("a_busy", busy[0], 1);
    n = 0; k = 0;
    while (!lon_v[0] && k < 20) begin
      if (!hp[0]) n++;
      step(1); k++;
    end
    chk("a_win",   n, 4);
    chk("a_lo_on", lon_v[0], 1);
    chk("a_hi_off", hp[0], 0);

    // dead=0 behaves as 1: LO->HI then HI->LO
    dc = 8'd0;
    h = 3'b001; l = 3'b000;
    step(3);
    n = 0; k = 0;
    while (!hp[0] && k < 20) begin
      if (!lon_v[0]) n++;
      step(1); k++;
    end
    chk("b_win_lh", n, 1);
    step(2);
    h = 3'b000; l = 3'b001;
    step(3);
    n = 0; k = 0;
    while (!lon_v[0] && k < 20) begin
      if (!hp[0]) n++;
      step(1); k++;
    end
    chk("b_win_hl", n, 1);
    l = 3'b000;
    step(6);

    // conflict on leg1 while HI
    dc = 8'd2;
    h = 3'b010;
    step(4);
    chk("c_hi", hp[1], 1);
    h = 3'b010; l = 3'b010;
    step(1);
    h = 3'b000; l = 3'b000;
    step(1);
    chk("c_fault", fault, 1);
    step(1);
    chk("c_off",  hp[1], 0);
    chk("c_busy", busy[1], 1);
    step(2);
    chk("c_busy_end", busy[1], 0);
    chk("c_lno_off",  lon_v[1], 0);
    step(4);
    chk("c_sticky", fault, 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
    chk("c_clear", fault, 0);
    h = 3'b010; l = 3'b010; clr = 1'b1;
    step(1);
    h = 3'b000; l = 3'b000; clr = 1'b0;
    step(1);
    chk("c_set_wins", fault, 1);
    chk("c_stay_off", hp[1], 0);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
    chk("c_clear2", fault, 0);
    en = 3'b101;
    h = 3'b010; l = 3'b010;
    step(1);
    h = 3'b000; l = 3'b000;
    step(2);
    chk("c_dis_nofault", fault, 0);
    en = '1;
    step(3);

    // force stop while leg2 in LO, dead=6
    dc = 8'd6;
    l = 3'b100;
    step(4);
    chk("d_lo", lon_v[2], 1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(1);
    chk("d_still_on", lon_v[2], 1);
    step(1);
    chk("d_off", lon_v[2], 0);
    n = 0; k = 0;
    while (busy[2] && k < 20) begin
      chk("d_both_off", {hp[2], lon_v[2]}, 2'b00);
      n++;
      step(1); k++;
    end
    chk("d_busy_len", n, 6);
    chk("d_relo", lon_v[2], 1);
    l = 3'b000;
    step(10);

    // reset while HI drops gate on next edge
    dc = 8'd5;
    h = 3'b001;
    step(4);
    chk("r_hi", hp[0], 1);
    rst_n = 1'b0;
    step(1);
    chk("r_hpo", hp, 3'b000);
    chk("r_busy", busy, 3'b000);
    rst_n = 1'b1;
    h = 3'b000;
    step(3);

    // random requests with overlap / dead window checks
    dcs[0] = 8'd3; dcs[1] = 8'd0; dcs[2] = 8'd6;
    for (int c = 0; c < 3; c++) begin
      h = '0; l = '0; en = '1; stop = 1'b0;
      step(20);
      dc = dcs[c];
      need = (dcs[c] < 1) ? 1 : int'(dcs[c]);
      for (int i = 0; i < N; i++) begin
        last[i] = 0;
        run[i]  = 0;
      end
      for (int t = 0; t < 400; t++) begin
        if ($urandom_range(3) == 0) begin
          h = N'($urandom);
          l = N'($urandom);
        end
        en   = N'($urandom | $urandom | $urandom);
        stop = ($urandom_range(31) == 0);
        step(1);
        chk("x_overlap", hp & lon_v, 0);
        for (int i = 0; i < N; i++) begin
          if (hp[i]) begin
            if (last[i] == 2) chk("x_win_lh", run[i] >= need, 1);
            last[i] = 1; run[i] = 0;
          end else if (lon_v[i]) begin
            if (last[i] == 1) chk("x_win_hl", run[i] >= need, 1);
            last[i] = 2; run[i] = 0;
          end else begin
            run[i]++;
          end
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
